// File: rtl/slice_config_loader.sv
// Word-serial bitstream loader for the fracturable-LUT carry slice: assembles one
// full frame, then presents it in parallel with a single-cycle config_en strobe.
module slice_config_loader #(
    parameter int S_XX_BASE  = 4,
    parameter int CFG_SIZE   = 2**S_XX_BASE + 1,
    parameter int NUM_LUTS   = 4,
    parameter int WORD_WIDTH = 8
) (
    input  logic                         config_clk,
    input  logic                         config_rst,
    input  logic                         start,
    input  logic [WORD_WIDTH-1:0]        bs_data,
    input  logic                         bs_valid,
    output logic                         bs_ready,
    output logic [NUM_LUTS*CFG_SIZE-1:0] luts_config_out,
    output logic                         config_use_cc_out,
    output logic                         config_en,
    output logic                         busy,
    output logic                         done
);

    localparam int LUT_BITS   = NUM_LUTS * CFG_SIZE;
    localparam int FRAME_BITS = LUT_BITS + 1;
    localparam int NUM_WORDS  = (FRAME_BITS + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int ASM_BITS   = NUM_WORDS * WORD_WIDTH;
    localparam int CNT_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT,
        DONE
    } state_e;

    state_e              state_q,  state_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [ASM_BITS-1:0] asm_q,    asm_d;
    logic [LUT_BITS-1:0] luts_q,   luts_d;
    logic                use_cc_q, use_cc_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        asm_d    = asm_q;
        luts_d   = luts_q;
        use_cc_d = use_cc_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            LOAD: begin
                // Restart wins over a word handshaken in the same cycle.
                if (start) begin
                    count_d = '0;
                end else if (bs_valid) begin
                    for (int k = 0; k < NUM_WORDS; k++) begin
                        if (count_q == CNT_W'(k)) begin
                            asm_d[k*WORD_WIDTH +: WORD_WIDTH] = bs_data;
                        end
                    end
                    if (count_q == LAST_WORD) begin
                        // Load outputs on the edge into COMMIT so they are valid with config_en.
                        state_d  = COMMIT;
                        count_d  = '0;
                        luts_d   = asm_d[FRAME_BITS-1:1];
                        use_cc_d = asm_d[0];
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge config_clk) begin
        if (config_rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            // NOTE: the assembly register is cleared on reset so a stale frame can never leak out.
            asm_q    <= '0;
            luts_q   <= '0;
            use_cc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            asm_q    <= asm_d;
            luts_q   <= luts_d;
            use_cc_q <= use_cc_d;
        end
    end

    assign bs_ready          = (state_q == LOAD);
    assign config_en         = (state_q == COMMIT);
    assign busy              = (state_q == LOAD) || (state_q == COMMIT);
    assign done              = (state_q == DONE);
    assign luts_config_out   = luts_q;
    assign config_use_cc_out = use_cc_q;

endmodule
